// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode/opext encodings, PSR flag positions and
// the immediate-form decode helpers used by the operand stage.
package alu_pkg;

  // Immediate forms are identified by opcode. Register forms use opcode 0000
  // with the operation carried in opext.
  localparam logic [3:0] OPC_RTYPE = 4'b0000;
  localparam logic [3:0] ADDI  = 4'b0101;
  localparam logic [3:0] ADDUI = 4'b0110;
  localparam logic [3:0] ADDCI = 4'b0111;
  localparam logic [3:0] LSHI  = 4'b1000;
  localparam logic [3:0] RSHI  = 4'b1110;

  localparam logic [3:0] AND   = 4'b0001;
  localparam logic [3:0] OR    = 4'b0010;
  localparam logic [3:0] XOR   = 4'b0011;
  localparam logic [3:0] LSH   = 4'b0100;
  localparam logic [3:0] ADD   = 4'b0101;
  localparam logic [3:0] ADDU  = 4'b0110;
  localparam logic [3:0] ADDC  = 4'b0111;
  localparam logic [3:0] ARSH  = 4'b1011;
  localparam logic [3:0] RSH   = 4'b1100;
  localparam logic [3:0] ALSH  = 4'b1101;
  localparam logic [3:0] NOT   = 4'b1111;

  // PSR bit positions (CLFZN).
  localparam int FLAG_C = 4;
  localparam int FLAG_L = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  function automatic logic is_imm(input logic [3:0] opcode);
    return (opcode == ADDI) || (opcode == ADDCI) || (opcode == ADDUI) ||
           (opcode == LSHI) || (opcode == RSHI);
  endfunction

  function automatic logic imm_signed(input logic [3:0] opcode);
    return (opcode == ADDI) || (opcode == ADDCI);
  endfunction

endpackage

// File: rtl/alu_operand_stage_if.sv
// Bus between the operand stage and its neighbours: instruction handshake,
// ALU operand bundle, writeback port and PSR readout.
interface alu_operand_stage_if #(parameter int W = 16);
  logic         in_valid;
  logic         in_ready;
  logic [15:0]  instr;
  logic         out_valid;
  logic         out_ready;
  logic [3:0]   alu_opcode;
  logic [3:0]   alu_opext;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [3:0]   alu_rdest;
  logic         wb_en;
  logic [3:0]   wb_addr;
  logic [W-1:0] wb_data;
  logic         flags_we;
  logic [4:0]   wb_flags;
  logic [4:0]   psr;

  // Environment side: issues instructions, drains bundles, drives writeback.
  modport master (
    output in_valid, instr, out_ready, wb_en, wb_addr, wb_data, flags_we, wb_flags,
    input  in_ready, out_valid, alu_opcode, alu_opext, alu_a, alu_b, alu_rdest, psr
  );

  // Operand stage side.
  modport slave (
    input  in_valid, instr, out_ready, wb_en, wb_addr, wb_data, flags_we, wb_flags,
    output in_ready, out_valid, alu_opcode, alu_opext, alu_a, alu_b, alu_rdest, psr
  );
endinterface

// File: rtl/alu_operand_stage_regfile16x16.sv
// 16x16 register file: two asynchronous read ports, one synchronous write
// port, asynchronous reset to zero. R0 is an ordinary register.
module regfile16x16 #(
  parameter int NREGS = 16,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         we_i,
  input  logic [3:0]   waddr_i,
  input  logic [W-1:0] wdata_i,
  input  logic [3:0]   raddr_a_i,
  output logic [W-1:0] rdata_a_o,
  input  logic [3:0]   raddr_b_i,
  output logic [W-1:0] rdata_b_o
);

  logic [W-1:0] regs_q [NREGS];

  // Storage: clear on reset, write one entry per edge when enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = regs_q[raddr_a_i];
  assign rdata_b_o = regs_q[raddr_b_i];

endmodule

// File: rtl/alu_operand_stage.sv
// Operand-fetch stage ahead of the 16-bit ALU: decodes the instruction,
// reads A = R[Rdest] and B = R[Rsrc] or extended imm8, and holds the bundle
// in a one-entry valid/ready register. Also takes ALU writeback and flags.
// Optional build macro: ALU_OPERAND_BYPASS_EN forwards a same-edge
// writeback into the operands being captured.
module alu_operand_stage
  import alu_pkg::*;
#(
  parameter int NREGS = 16,
  parameter int W     = 16
) (
  input logic clk,
  input logic reset,
  alu_operand_stage_if.slave bus
);

  logic [3:0]   opcode, rdest, opext, rsrc;
  logic [7:0]   imm8;
  logic [W-1:0] rf_a, rf_b;
  logic [W-1:0] opnd_a, rsrc_val, imm_ext, opnd_b;
  logic         accept;

  logic         out_valid_q, out_valid_d;
  logic [3:0]   opcode_q, opcode_d;
  logic [3:0]   opext_q, opext_d;
  logic [3:0]   rdest_q, rdest_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [4:0]   psr_q;

  assign opcode = bus.instr[15:12];
  assign rdest  = bus.instr[11:8];
  assign opext  = bus.instr[7:4];
  assign rsrc   = bus.instr[3:0];
  assign imm8   = bus.instr[7:0];

  regfile16x16 #(.NREGS(NREGS), .W(W)) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .we_i      (bus.wb_en),
    .waddr_i   (bus.wb_addr),
    .wdata_i   (bus.wb_data),
    .raddr_a_i (rdest),
    .rdata_a_o (rf_a),
    .raddr_b_i (rsrc),
    .rdata_b_o (rf_b)
  );

`ifdef ALU_OPERAND_BYPASS_EN
  assign opnd_a   = (bus.wb_en && (bus.wb_addr == rdest)) ? bus.wb_data : rf_a;
  assign rsrc_val = (bus.wb_en && (bus.wb_addr == rsrc))  ? bus.wb_data : rf_b;
`else
  // Without forwarding the captured operand is the pre-write value; the
  // issuer must leave a bubble after a writeback it depends on.
  assign opnd_a   = rf_a;
  assign rsrc_val = rf_b;
`endif

  assign imm_ext = imm_signed(opcode) ? {{(W-8){imm8[7]}}, imm8} : {{(W-8){1'b0}}, imm8};
  assign opnd_b  = is_imm(opcode) ? imm_ext : rsrc_val;

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // Output register next state: load on accept, drop valid on a bare drain.
  always_comb begin
    out_valid_d = out_valid_q;
    opcode_d    = opcode_q;
    opext_d     = opext_q;
    rdest_d     = rdest_q;
    a_d         = a_q;
    b_d         = b_q;
    if (accept) begin
      out_valid_d = 1'b1;
      opcode_d    = opcode;
      opext_d     = opext;
      rdest_d     = rdest;
      a_d         = opnd_a;
      b_d         = opnd_b;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      opcode_q    <= '0;
      opext_q     <= '0;
      rdest_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      opcode_q    <= opcode_d;
      opext_q     <= opext_d;
      rdest_q     <= rdest_d;
      a_q         <= a_d;
      b_q         <= b_d;
    end
  end

  // Processor status register, loaded from the ALU flags on request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             psr_q <= '0;
    else if (bus.flags_we) psr_q <= bus.wb_flags;
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.alu_opcode = opcode_q;
  assign bus.alu_opext  = opext_q;
  assign bus.alu_rdest  = rdest_q;
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.psr        = psr_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Testbench for alu_operand_stage: directed scenarios plus random traffic,
// all compared against a behavioural model of the stage.
module tb_alu_operand_stage;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_operand_stage_if bus ();
  alu_operand_stage dut (.clk(clk), .reset(reset), .bus(bus));

  int errors = 0;
  int checks = 0;

  logic [15:0] m_regs [16];
  logic [4:0]  m_psr;
  logic        m_ov;
  logic [3:0]  m_op, m_ox, m_rd;
  logic [15:0] m_a, m_b;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 16'h0;
    m_psr = 5'h0; m_ov = 1'b0;
    m_op = 4'h0; m_ox = 4'h0; m_rd = 4'h0; m_a = 16'h0; m_b = 16'h0;
  endtask

  function automatic logic [15:0] m_read(input logic [3:0] idx);
    logic [15:0] v;
    v = m_regs[idx];
`ifdef ALU_OPERAND_BYPASS_EN
    if (bus.wb_en && bus.wb_addr == idx) v = bus.wb_data;
`endif
    return v;
  endfunction

  // Apply one clock edge worth of behaviour to the model, from current inputs.
  task automatic model_edge();
    logic acc;
    logic [7:0] imm;
    acc = bus.in_valid && (!m_ov || bus.out_ready);
    if (acc) begin
      m_op = bus.instr[15:12];
      m_rd = bus.instr[11:8];
      m_ox = bus.instr[7:4];
      m_a  = m_read(bus.instr[11:8]);
      imm  = bus.instr[7:0];
      case (bus.instr[15:12])
        4'd5, 4'd7:         m_b = (imm >= 8'd128) ? (16'hFF00 + 16'(imm)) : 16'(imm);
        4'd6, 4'd8, 4'd14:  m_b = 16'(imm);
        default:            m_b = m_read(bus.instr[3:0]);
      endcase
      m_ov = 1'b1;
    end else if (m_ov && bus.out_ready) begin
      m_ov = 1'b0;
    end
    if (bus.wb_en) m_regs[bus.wb_addr] = bus.wb_data;
    if (bus.flags_we) m_psr = bus.wb_flags;
  endtask

  task automatic check_all(input string tag);
    check_val({tag, ".out_valid"}, 16'(bus.out_valid), 16'(m_ov));
    check_val({tag, ".in_ready"}, 16'(bus.in_ready), 16'(!m_ov || bus.out_ready));
    check_val({tag, ".psr"}, 16'(bus.psr), 16'(m_psr));
    check_val({tag, ".opcode"}, 16'(bus.alu_opcode), 16'(m_op));
    check_val({tag, ".opext"}, 16'(bus.alu_opext), 16'(m_ox));
    check_val({tag, ".rdest"}, 16'(bus.alu_rdest), 16'(m_rd));
    check_val({tag, ".a"}, bus.alu_a, m_a);
    check_val({tag, ".b"}, bus.alu_b, m_b);
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic set_idle();
    bus.in_valid = 1'b0; bus.instr = 16'h0; bus.out_ready = 1'b1;
    bus.wb_en = 1'b0; bus.wb_addr = 4'h0; bus.wb_data = 16'h0;
    bus.flags_we = 1'b0; bus.wb_flags = 5'h0;
  endtask

  task automatic write_reg(input logic [3:0] addr, input logic [15:0] data);
    bus.wb_en = 1'b1; bus.wb_addr = addr; bus.wb_data = data;
    tick("wr");
    bus.wb_en = 1'b0;
  endtask

  task automatic issue(input logic [15:0] ins, input string tag);
    bus.in_valid = 1'b1; bus.instr = ins;
    tick(tag);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    set_idle();
    m_reset();
    reset = 1'b1;
    #12;
    check_all("rst");
    @(negedge clk);
    reset = 1'b0;
    tick("post_rst");
    check_val("rst_in_ready", 16'(bus.in_ready), 16'h1);

    issue(16'h0303, "read_r3");
    check_val("r3_a", bus.alu_a, 16'h0000);
    check_val("r3_psr", 16'(bus.psr), 16'h0000);

    write_reg(4'd2, 16'h0010);
    issue(16'h52FE, "addi");
    check_val("addi_a", bus.alu_a, 16'h0010);
    check_val("addi_b", bus.alu_b, 16'hFFFE);
    issue(16'h62FE, "addui");
    check_val("addui_b", bus.alu_b, 16'h00FE);

    write_reg(4'd1, 16'h1234);
    write_reg(4'd5, 16'h00FF);
    issue(16'h0155, "add");
    check_val("add_a", bus.alu_a, 16'h1234);
    check_val("add_b", bus.alu_b, 16'h00FF);
    check_val("add_rdest", 16'(bus.alu_rdest), 16'h0001);
    check_val("add_opext", 16'(bus.alu_opext), 16'h0005);

    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.instr = 16'h52FE;
    for (int i = 0; i < 3; i++) begin
      tick("stall");
      check_val("stall_a", bus.alu_a, 16'h1234);
      check_val("stall_b", bus.alu_b, 16'h00FF);
      check_val("stall_in_ready", 16'(bus.in_ready), 16'h0);
    end
    bus.out_ready = 1'b1;
    tick("release");
    check_val("release_valid", 16'(bus.out_valid), 16'h1);
    check_val("release_b", bus.alu_b, 16'hFFFE);
    bus.in_valid = 1'b0;
    tick("drain");
    check_val("drain_valid", 16'(bus.out_valid), 16'h0);

    write_reg(4'd4, 16'h1111);
    bus.wb_en = 1'b1; bus.wb_addr = 4'd4; bus.wb_data = 16'hBEEF;
    bus.in_valid = 1'b1; bus.instr = 16'h0154;
    tick("hazard");
`ifdef ALU_OPERAND_BYPASS_EN
    check_val("hazard_b", bus.alu_b, 16'hBEEF);
`else
    check_val("hazard_b", bus.alu_b, 16'h1111);
`endif
    set_idle();
    issue(16'h0454, "after_hazard");
    check_val("after_hazard_a", bus.alu_a, 16'hBEEF);

    bus.flags_we = 1'b1; bus.wb_flags = 5'b10010;
    tick("psr_load");
    check_val("psr_load", 16'(bus.psr), 16'h0012);
    check_val("psr_carry", 16'(bus.psr[4]), 16'h0001);
    bus.flags_we = 1'b0; bus.wb_flags = 5'b01101;
    tick("psr_hold");
    check_val("psr_hold", 16'(bus.psr), 16'h0012);

    for (int i = 0; i < 400; i++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.instr     = 16'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.wb_en     = 1'($urandom_range(0, 1));
      bus.wb_addr   = 4'($urandom_range(0, 15));
      bus.wb_data   = 16'($urandom);
      bus.flags_we  = ($urandom_range(0, 3) == 0);
      bus.wb_flags  = 5'($urandom);
      tick("rnd");
    end

    set_idle();
    bus.out_ready = 1'b0;
    issue(16'h0155, "pre_rst");
    check_val("pre_rst_valid", 16'(bus.out_valid), 16'h1);
    bus.wb_en = 1'b1; bus.wb_addr = 4'd7; bus.wb_data = 16'hA5A5;
    #3;
    reset = 1'b1;
    #1;
    check_val("midrst_valid", 16'(bus.out_valid), 16'h0);
    m_reset();
    check_all("midrst");
    @(negedge clk);
    reset = 1'b0;
    set_idle();
    issue(16'h0707, "post_midrst");
    check_val("post_midrst_a", bus.alu_a, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
